mon_exp_ctrl: RTL
=================

# mon_exp_ctrl

Left-to-right square-and-multiply sequencer for RSA modular exponentiation; sits directly upstream of the Montgomery product unit (`mon_prod`) and is its only driver. It accepts a Montgomery-domain base, the Montgomery one, an exponent and a modulus. It issues one Montgomery product per step over a start/stop handshake, collecting each result. A final product by 1 returns the result to the normal domain.

## Interface
- `bitLen`, 1024, operand/modulus width; must match the multiplier.
- `expLen`, 1024, exponent width.
- `countWidth`, 4, width of `num_words`; passed through unchanged.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_bar`  in  bitLen  base·R mod M; R = 4^num_words.
- `one_bar`  in  bitLen  R mod M.
- `E`  in  expLen  exponent.
- `M`  in  bitLen  odd modulus.
- `num_words`  in  countWidth  radix-4 digit count.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `result` valid from this cycle.
- `result`  out  bitLen  base^E mod M; held until the next accepted `start`.
- `mp_start`  out  1  one-cycle pulse to the multiplier.
- `mp_A`, `mp_B`, `mp_M`  out  bitLen  multiplier operands; stable from `mp_start` until the product is captured.
- `mp_num_words`  out  countWidth  registered copy of `num_words`.
- `mp_stop`  in  1  multiplier idle/finished flag.
- `mp_P`  in  bitLen  multiplier product.

## Operation
- On `start` in IDLE, register `base_bar`, `one_bar`, `E`, `M` and `num_words`.
  - Set X = `one_bar`.
  - Set bit index i = expLen-1.
  - Go to the step decision.
- States: IDLE, SCAN (only with the macro), ISSUE, WAIT_BUSY, WAIT_DONE, NEXT, FINISH.
- Op register values: SQ, MUL, CONV.
- Step decision for bit i:
  - Op=SQ: operands (X, X).
  - If E[i]=1 after the SQ, op=MUL: operands (X, base_bar).
  - After bit 0 is done, op=CONV: operands (X, 1).
- ISSUE: drive operands and assert `mp_start` for 1 cycle. Then go to WAIT_BUSY.
- WAIT_BUSY: stay until `mp_stop`=0. This step exists because `mp_stop` is also high while the multiplier is idle.
- WAIT_DONE: stay until `mp_stop`=1. In that cycle capture X ← `mp_P`, then go to NEXT.
- NEXT chooses the next operation:
  - After SQ: go to MUL if E[i]=1. Otherwise decrement i, or go to CONV when i was 0.
  - After MUL: decrement i, or go to CONV when i was 0.
  - After CONV: go to FINISH.
- FINISH: `result` ← X, pulse `done`, deassert `busy`, return to IDLE.
- `start` while busy is ignored; there is no queue.
- E=0: every step is SQ of R mod M, so the result is 1 mod M.

## Timing
- Reset values: every output is 0; state IDLE; X, i and the captured inputs are 0.
- Reset mid-operation: return to IDLE at once and drop `mp_start`. No `done` is produced. The multiplier is left to finish on its own, and its stale product is never captured.
- `busy` rises 1 cycle after accepted `start`.
- Overhead per product: 4 cycles plus the multiplier latency Lm.
- Total latency: roughly (squares + multiplies + 1)·(Lm+4) + 2 cycles.
- `mp_A`/`mp_B`/`mp_M` are registered and never change while in WAIT_BUSY or WAIT_DONE.
- `done` and `result` update on the same edge. `result` is not modified at any other time.
- Arithmetic:
  - No arithmetic beyond index decrement; all modular work is in the multiplier.
  - i never wraps; reaching 0 goes to CONV.

## Configuration
- `MON_EXP_SKIP_LZ_EN` defined:
  - After `start`, SCAN tests E[i] one bit per cycle, decrementing i while the bit is 0.
  - At the first 1 bit, load X ← `base_bar` directly, with no SQ or MUL for that bit, and continue from bit i-1.
  - If E=0, SCAN exits to CONV with X=`one_bar`.
- Not defined: SCAN is absent and all expLen bits are processed from the MSB.
- The result is identical either way; only the op count and latency differ.

## Test plan
The bench uses a behavioural multiplier returning A·B·R⁻¹ mod M after Lm=12 cycles, with `mp_stop` high when idle. Parameters: bitLen=16, expLen=4, num_words=5, so R=1024. Inputs: M=13, one_bar=10, base_bar=7 (base 2).
- E=5 → `done` with `result`=6. Without the macro, 7 `mp_start` pulses (4 SQ, 2 MUL, 1 CONV); with it, 4 pulses.
- E=0 → `result`=1. Without the macro, 5 pulses; with it, 1 pulse (CONV only).
- E=12 → `result`=1 (Fermat); `busy` is high throughout and `done` is exactly 1 pulse.
- `start` pulsed again mid-run with E=3 → ignored; the first run completes with its own result and `result` is unchanged until `done`.
- `rst` asserted in WAIT_DONE → all outputs 0 on the next observation. A new `start` with E=5 then gives 6.
- Multiplier delays the `mp_stop` fall by 3 extra cycles → no capture before the busy phase, and the result is still correct.

Source files
------------

// File: rtl/mon_exp_ctrl.sv
// mon_exp_ctrl
// Left-to-right square-and-multiply sequencer for RSA modular exponentiation.
// It is the only driver of the Montgomery product unit (mon_prod). Each step
// issues one product over the mp_start / mp_stop handshake and captures the
// product back into the accumulator X. A final product by 1 takes the result
// out of the Montgomery domain.
//
// Optional feature: define MON_EXP_SKIP_LZ_EN to skip the exponent's leading
// zeros in a SCAN state and seed X with base_bar at the first set bit.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           one-cycle request, sampled only in IDLE
//   base_bar        base*R mod M            one_bar   R mod M
//   E               exponent                M         odd modulus
//   num_words       radix-4 digit count, forwarded as mp_num_words
//   busy            high from the cycle after an accepted start until done
//   done, result    one-cycle done pulse; result = base^E mod M, held
//   mp_start        one-cycle pulse to the multiplier
//   mp_A/B/M        multiplier operands, held from mp_start to capture
//   mp_num_words    registered copy of num_words
//   mp_stop, mp_P   multiplier idle/finished flag and product
module mon_exp_ctrl #(
  parameter int unsigned bitLen     = 1024,
  parameter int unsigned expLen     = 1024,
  parameter int unsigned countWidth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [bitLen-1:0]     base_bar,
  input  logic [bitLen-1:0]     one_bar,
  input  logic [expLen-1:0]     E,
  input  logic [bitLen-1:0]     M,
  input  logic [countWidth-1:0] num_words,
  output logic                  busy,
  output logic                  done,
  output logic [bitLen-1:0]     result,
  output logic                  mp_start,
  output logic [bitLen-1:0]     mp_A,
  output logic [bitLen-1:0]     mp_B,
  output logic [bitLen-1:0]     mp_M,
  output logic [countWidth-1:0] mp_num_words,
  input  logic                  mp_stop,
  input  logic [bitLen-1:0]     mp_P
);

  localparam int unsigned IDX_W = (expLen > 1) ? $clog2(expLen) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef MON_EXP_SKIP_LZ_EN
    S_SCAN,
`endif
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    OP_SQ,
    OP_MUL,
    OP_CONV
  } op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [bitLen-1:0]     x_q, x_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [expLen-1:0]     e_q, e_d;
  logic [bitLen-1:0]     base_q, base_d;
  logic [bitLen-1:0]     one_q, one_d;
  logic [bitLen-1:0]     m_q, m_d;
  logic [countWidth-1:0] nw_q, nw_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [bitLen-1:0]     result_q, result_d;
  logic                  mp_start_q, mp_start_d;
  logic [bitLen-1:0]     mp_a_q, mp_a_d;
  logic [bitLen-1:0]     mp_b_q, mp_b_d;
  logic [bitLen-1:0]     mp_m_q, mp_m_d;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    idx_d      = idx_q;
    e_d        = e_q;
    base_d     = base_q;
    one_d      = one_q;
    m_d        = m_q;
    nw_d       = nw_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    mp_start_d = 1'b0;
    mp_a_d     = mp_a_q;
    mp_b_d     = mp_b_q;
    mp_m_d     = mp_m_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_bar;
          one_d  = one_bar;
          e_d    = E;
          m_d    = M;
          nw_d   = num_words;
          x_d    = one_bar;
          idx_d  = IDX_W'(expLen - 1);
          op_d   = OP_SQ;
          busy_d = 1'b1;
`ifdef MON_EXP_SKIP_LZ_EN
          state_d = S_SCAN;
`else
          state_d = S_ISSUE;
`endif
        end
      end

`ifdef MON_EXP_SKIP_LZ_EN
      // Walk down leading zeros; the first set bit seeds X with the base.
      S_SCAN: begin
        if (e_q[idx_q]) begin
          x_d = base_q;
          if (idx_q == '0) begin
            op_d = OP_CONV;
          end else begin
            idx_d = idx_q - IDX_W'(1);
            op_d  = OP_SQ;
          end
          state_d = S_ISSUE;
        end else if (idx_q == '0) begin
          op_d    = OP_CONV;
          state_d = S_ISSUE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
`endif

      // Only issue to an idle multiplier, so a product still running from
      // before a reset is allowed to drain and is never captured.
      S_ISSUE: begin
        if (mp_stop) begin
          mp_start_d = 1'b1;
          mp_a_d     = x_q;
          mp_m_d     = m_q;
          case (op_q)
            OP_SQ:   mp_b_d = x_q;
            OP_MUL:  mp_b_d = base_q;
            default: mp_b_d = bitLen'(1);
          endcase
          state_d = S_WAIT_BUSY;
        end
      end

      // mp_stop is also high when idle; wait for the multiplier to go busy.
      S_WAIT_BUSY: begin
        if (!mp_stop) state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (mp_stop) begin
          x_d     = mp_P;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        state_d = S_ISSUE;
        case (op_q)
          OP_SQ: begin
            if (e_q[idx_q]) begin
              op_d = OP_MUL;
            end else if (idx_q == '0) begin
              op_d = OP_CONV;
            end else begin
              idx_d = idx_q - IDX_W'(1);
              op_d  = OP_SQ;
            end
          end
          OP_MUL: begin
            if (idx_q == '0) begin
              op_d = OP_CONV;
            end else begin
              idx_d = idx_q - IDX_W'(1);
              op_d  = OP_SQ;
            end
          end
          default: state_d = S_FINISH;
        endcase
      end

      S_FINISH: begin
        result_d = x_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_SQ;
      x_q        <= '0;
      idx_q      <= '0;
      e_q        <= '0;
      base_q     <= '0;
      one_q      <= '0;
      m_q        <= '0;
      nw_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      mp_start_q <= 1'b0;
      mp_a_q     <= '0;
      mp_b_q     <= '0;
      mp_m_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x_q        <= x_d;
      idx_q      <= idx_d;
      e_q        <= e_d;
      base_q     <= base_d;
      one_q      <= one_d;
      m_q        <= m_d;
      nw_q       <= nw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      mp_start_q <= mp_start_d;
      mp_a_q     <= mp_a_d;
      mp_b_q     <= mp_b_d;
      mp_m_q     <= mp_m_d;
    end
  end

  // one_bar is kept with the other captured operands; X is seeded from the
  // port directly at start, so the copy itself is not read.
  logic unused_one;
  assign unused_one = ^one_q;

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign mp_start     = mp_start_q;
  assign mp_A         = mp_a_q;
  assign mp_B         = mp_b_q;
  assign mp_M         = mp_m_q;
  assign mp_num_words = nw_q;

endmodule
